// File: rtl/ucsbece154a_lsu.sv
// ucsbece154a_lsu
//   Load/store unit between the single-cycle datapath and a word-wide data
//   memory that has a single write enable and no byte enables.
//   - Loads: same-cycle lane extract with sign/zero extension.
//   - Word stores: passed straight through to the memory.
//   - Byte/half stores: two-cycle read-modify-write. Cycle 1 stalls the
//     datapath and registers the merged word. Cycle 2 writes it.
//   - Misaligned or reserved-size requests are flagged and suppressed.
// Ports
//   clk, reset      clock (posedge) / asynchronous active-high reset
//   req_i, we_i     request valid / 1 = store
//   size_i          00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i      loads: 1 = zero-extend, 0 = sign-extend
//   addr_i, wdata_i byte address / right-aligned store data
//   rdata_o         extended load data (0 when not a valid load)
//   stall_o         datapath must hold PC and inputs
//   misaligned_o    current request is misaligned or reserved
//   mis_sticky_o    set by any flagged request until reset
//   dmem_a_o/we_o/wd_o/rd_i  data memory interface
module ucsbece154a_lsu (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        misaligned_o,
   output logic        mis_sticky_o,
   output logic [31:0] dmem_a_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_wd_o,
   input  logic [31:0] dmem_rd_i
);

   typedef enum logic {IDLE, WRITE} state_e;

   state_e      state_q, state_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] addr_q, addr_d;
   logic        mis_sticky_q, mis_sticky_d;

   logic        bad_align;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] merged;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         merge_q      <= '0;
         addr_q       <= '0;
         mis_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         merge_q      <= merge_d;
         addr_q       <= addr_d;
         mis_sticky_q <= mis_sticky_d;
      end
   end

   // Alignment check on the raw request; gated by state/req below.
   always_comb begin
      bad_align = 1'b0;
      case (size_i)
         2'b00:   bad_align = 1'b0;
         2'b01:   bad_align = addr_i[0];
         2'b10:   bad_align = (addr_i[1:0] != 2'b00);
         default: bad_align = 1'b1;
      endcase
   end

   // Lane extraction and store-lane merge, little-endian.
   always_comb begin
      byte_lane = dmem_rd_i[7:0];
      half_lane = dmem_rd_i[15:0];
      merged    = dmem_rd_i;
      case (addr_i[1:0])
         2'b00:   byte_lane = dmem_rd_i[7:0];
         2'b01:   byte_lane = dmem_rd_i[15:8];
         2'b10:   byte_lane = dmem_rd_i[23:16];
         default: byte_lane = dmem_rd_i[31:24];
      endcase
      if (addr_i[1]) half_lane = dmem_rd_i[31:16];
      else           half_lane = dmem_rd_i[15:0];
      if (size_i == 2'b00) begin
         case (addr_i[1:0])
            2'b00:   merged[7:0]   = wdata_i[7:0];
            2'b01:   merged[15:8]  = wdata_i[7:0];
            2'b10:   merged[23:16] = wdata_i[7:0];
            default: merged[31:24] = wdata_i[7:0];
         endcase
      end else begin
         if (addr_i[1]) merged[31:16] = wdata_i[15:0];
         else           merged[15:0]  = wdata_i[15:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      merge_d      = merge_q;
      addr_d       = addr_q;
      mis_sticky_d = mis_sticky_q;
      rdata_o      = '0;
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      dmem_a_o     = {addr_i[31:2], 2'b00};
      dmem_we_o    = 1'b0;
      dmem_wd_o    = wdata_i;

      case (state_q)
         IDLE: begin
            if (req_i && bad_align) begin
               misaligned_o = 1'b1;
               mis_sticky_d = 1'b1;
            end else if (req_i && !we_i) begin
               case (size_i)
                  2'b00:   rdata_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
                  2'b01:   rdata_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
                  default: rdata_o = dmem_rd_i;
               endcase
            end else if (req_i && we_i) begin
               if (size_i == 2'b10) begin
                  dmem_we_o = 1'b1;
               end else begin
                  // Merged word is registered so dmem rd never feeds wd combinationally.
                  stall_o = 1'b1;
                  merge_d = merged;
                  addr_d  = {addr_i[31:2], 2'b00};
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            dmem_a_o  = addr_q;
            dmem_wd_o = merge_q;
            dmem_we_o = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mis_sticky_o = mis_sticky_q;

endmodule

// File: tb/tb_ucsbece154a_lsu.sv
module tb_ucsbece154a_lsu;

   logic        clk;
   logic        reset;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        misaligned_o;
   logic        mis_sticky_o;
   logic [31:0] dmem_a_o;
   logic        dmem_we_o;
   logic [31:0] dmem_wd_o;
   logic [31:0] dmem_rd_i;

   logic [31:0] mem [0:63];

   int tests_run;
   int tests_failed;

   ucsbece154a_lsu dut (
      .clk          (clk),
      .reset        (reset),
      .req_i        (req_i),
      .we_i         (we_i),
      .size_i       (size_i),
      .unsigned_i   (unsigned_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .stall_o      (stall_o),
      .misaligned_o (misaligned_o),
      .mis_sticky_o (mis_sticky_o),
      .dmem_a_o     (dmem_a_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_wd_o    (dmem_wd_o),
      .dmem_rd_i    (dmem_rd_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural data memory: combinational read, write on posedge.
   assign dmem_rd_i = mem[dmem_a_o[7:2]];
   always @(posedge clk) begin
      if (dmem_we_o) mem[dmem_a_o[7:2]] <= dmem_wd_o;
   end

   task automatic drive(input logic r, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_i = r; we_i = w; size_i = s; unsigned_i = u; addr_i = a; wdata_i = d;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      tests_run++;
      if ({stall_o, dmem_we_o, mis_sticky_o, misaligned_o, rdata_o} !== 36'h0) begin
         tests_failed++;
         $display("FAIL reset_state: stall=%b we=%b sticky=%b mis=%b rdata=%h, expected all 0",
                  stall_o, dmem_we_o, mis_sticky_o, misaligned_o, rdata_o);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_loads();
      logic [1:0]  sz [5];
      logic        un [5];
      logic [31:0] ad [5];
      logic [31:0] ex [5];
      sz = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
      un = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ad = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10};
      ex = '{32'hFFFFFFB3, 32'h000000B3, 32'hFFFF8091, 32'h00008091, 32'h8091A2B3};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, sz[i], un[i], ad[i], 32'h0);
         tests_run++;
         if (rdata_o !== ex[i] || stall_o !== 1'b0 || dmem_we_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_%0d: rdata=%h stall=%b we=%b, expected rdata=%h stall=0 we=0",
                     i, rdata_o, stall_o, dmem_we_o, ex[i]);
         end
      end
   endtask

   task automatic test_sub_store();
      drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000EE);
      tests_run++;
      if (stall_o !== 1'b1 || dmem_we_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_cycle1: stall=%b we=%b, expected stall=1 we=0", stall_o, dmem_we_o);
      end
      // req drops in the write cycle; it must be ignored.
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      tests_run++;
      if (dmem_we_o !== 1'b1 || dmem_wd_o !== 32'h8091EEB3 || dmem_a_o !== 32'h10 || stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_cycle2: we=%b wd=%h a=%h stall=%b, expected we=1 wd=8091eeb3 a=10 stall=0",
                  dmem_we_o, dmem_wd_o, dmem_a_o, stall_o);
      end
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      tests_run++;
      if (rdata_o !== 32'h8091EEB3) begin
         tests_failed++;
         $display("FAIL sb_readback: rdata=%h, expected 8091eeb3", rdata_o);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
      tests_run++;
      if (stall_o !== 1'b1 || dmem_we_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL sh_cycle1: stall=%b we=%b, expected stall=1 we=0", stall_o, dmem_we_o);
      end
      drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
      tests_run++;
      if (dmem_we_o !== 1'b1 || dmem_wd_o !== 32'h1234EEB3 || stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL sh_cycle2: we=%b wd=%h stall=%b, expected we=1 wd=1234eeb3 stall=0",
                  dmem_we_o, dmem_wd_o, stall_o);
      end
      drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h000000AA);
      tests_run++;
      if (stall_o !== 1'b1 || dmem_we_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_sb_cycle1: stall=%b we=%b, expected stall=1 we=0", stall_o, dmem_we_o);
      end
      drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h000000AA);
      tests_run++;
      if (dmem_we_o !== 1'b1 || dmem_wd_o !== 32'h1234EEAA) begin
         tests_failed++;
         $display("FAIL b2b_sb_cycle2: we=%b wd=%h, expected we=1 wd=1234eeaa", dmem_we_o, dmem_wd_o);
      end
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      tests_run++;
      if (rdata_o !== 32'h1234EEAA || stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_readback: rdata=%h stall=%b, expected 1234eeaa stall=0", rdata_o, stall_o);
      end
   endtask

   task automatic test_word_store();
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
      tests_run++;
      if (dmem_we_o !== 1'b1 || dmem_wd_o !== 32'hDEADBEEF || dmem_a_o !== 32'h14 || stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL sw: we=%b wd=%h a=%h stall=%b, expected we=1 wd=deadbeef a=14 stall=0",
                  dmem_we_o, dmem_wd_o, dmem_a_o, stall_o);
      end
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      tests_run++;
      if (rdata_o !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL sw_readback: rdata=%h, expected deadbeef", rdata_o);
      end
   endtask

   task automatic test_misaligned();
      tests_run++;
      if (mis_sticky_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL sticky_initial: sticky=%b, expected 0", mis_sticky_o);
      end
      drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
      tests_run++;
      if (misaligned_o !== 1'b1 || rdata_o !== 32'h0 || stall_o !== 1'b0 || dmem_we_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL lh_misaligned: mis=%b rdata=%h stall=%b we=%b, expected mis=1 rdata=0 stall=0 we=0",
                  misaligned_o, rdata_o, stall_o, dmem_we_o);
      end
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h16, 32'h12345678);
      tests_run++;
      if (misaligned_o !== 1'b1 || dmem_we_o !== 1'b0 || mis_sticky_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL sw_misaligned: mis=%b we=%b sticky=%b, expected mis=1 we=0 sticky=1",
                  misaligned_o, dmem_we_o, mis_sticky_o);
      end
      drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      tests_run++;
      if (misaligned_o !== 1'b1 || rdata_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL size_reserved: mis=%b rdata=%h, expected mis=1 rdata=0", misaligned_o, rdata_o);
      end
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      tests_run++;
      if (mis_sticky_o !== 1'b1 || misaligned_o !== 1'b0 || mem[5] !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL sticky_hold: sticky=%b mis=%b mem14=%h, expected sticky=1 mis=0 mem14=deadbeef",
                  mis_sticky_o, misaligned_o, mem[5]);
      end
   endtask

   task automatic test_reset_in_write();
      drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055);
      drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055);
      tests_run++;
      if (dmem_we_o !== 1'b1 || dmem_wd_o !== 32'h1234EE55) begin
         tests_failed++;
         $display("FAIL rst_write_entry: we=%b wd=%h, expected we=1 wd=1234ee55", dmem_we_o, dmem_wd_o);
      end
      reset = 1'b1;
      req_i = 1'b0;
      #1;
      tests_run++;
      if (dmem_we_o !== 1'b0 || stall_o !== 1'b0 || mis_sticky_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_in_write: we=%b stall=%b sticky=%b, expected we=0 stall=0 sticky=0",
                  dmem_we_o, stall_o, mis_sticky_o);
      end
      @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if (mem[4] !== 32'h1234EEAA) begin
         tests_failed++;
         $display("FAIL rst_write_lost: mem10=%h, expected 1234eeaa", mem[4]);
      end
      // Back in IDLE: a load is served immediately, no stall.
      drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      tests_run++;
      if (rdata_o !== 32'h000000EE || stall_o !== 1'b0 || dmem_we_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_idle_load: rdata=%h stall=%b we=%b, expected 000000ee stall=0 we=0",
                  rdata_o, stall_o, dmem_we_o);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
      addr_i = '0; wdata_i = '0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[4] = 32'h8091A2B3;

      test_reset();
      test_loads();
      test_sub_store();
      test_back_to_back();
      test_word_store();
      test_misaligned();
      test_reset_in_write();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
